// File: rtl/shift_acc_lanes_pkg.sv
// shift_acc_pkg: shared state encoding and saturation helpers for shift_acc_lanes.
// Saturation logic is only used when SHIFT_ACC_SAT_EN is defined.
package shift_acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    // Largest positive two's-complement value of a size-bit word.
    function automatic longint sat_max(int unsigned size);
        return (longint'(1) <<< (size - 1)) - 1;
    endfunction

    // Most negative two's-complement value of a size-bit word.
    function automatic longint sat_min(int unsigned size);
        return -(longint'(1) <<< (size - 1));
    endfunction

    // A left shift loses the value unless the shifted-out bits and the new MSB
    // all repeat the old sign bit; 'top' holds those bits plus the old sign.
    function automatic logic shift_ovf(logic [63:0] top, int unsigned bits);
        logic [63:0] mask;
        mask = (64'd1 << bits) - 64'd1;
        return ((top & mask) != '0) && ((top & mask) != mask);
    endfunction

endpackage

// File: rtl/shift_acc_lanes_lane.sv
// shift_acc_lane: single-lane datapath, acc <= (acc << SHIFT) + pp.
// Defining SHIFT_ACC_SAT_EN enables signed clamping with a sticky sat flag.
module shift_acc_lane
    import shift_acc_pkg::*;
#(
    parameter int unsigned SIZE  = 18,
    parameter int unsigned SHIFT = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [SIZE-1:0] pp,
    output logic [SIZE-1:0] acc,
    output logic            sat
);

    logic [SIZE-1:0] shifted;
    logic [SIZE-1:0] sum;
    logic [SIZE-1:0] next;

    // Modulo shift-and-add of the incoming digit.
    always_comb begin
        shifted = {acc[SIZE-1-SHIFT:0], {SHIFT{1'b0}}};
        sum     = shifted + pp;
    end

`ifdef SHIFT_ACC_SAT_EN
    localparam logic [SIZE-1:0] MAX = SIZE'(sat_max(SIZE));
    localparam logic [SIZE-1:0] MIN = SIZE'(sat_min(SIZE));

    logic sh_ovf;
    logic add_ovf;
    logic ovf;

    // Clamp on overflow. A shift overflow leaves |acc<<SHIFT| >= 2^(SIZE-1),
    // which no in-range pp can flip, so the true sign is the old sign;
    // otherwise only a same-sign add can overflow and pp carries the sign.
    always_comb begin
        sh_ovf  = shift_ovf(64'(acc[SIZE-1:SIZE-1-SHIFT]), SHIFT + 1);
        add_ovf = (shifted[SIZE-1] == pp[SIZE-1]) && (sum[SIZE-1] != shifted[SIZE-1]);
        ovf     = sh_ovf | add_ovf;
        next    = sum;
        if (ovf) begin
            next = (sh_ovf ? acc[SIZE-1] : pp[SIZE-1]) ? MIN : MAX;
        end
    end

    // Sticky saturation flag, cleared by reset or a fresh load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat <= 1'b0;
        end else if (load) begin
            sat <= 1'b0;
        end else if (step) begin
            sat <= sat | ovf;
        end
    end
`else
    // Pure modulo wrap.
    always_comb begin
        next = sum;
    end

    assign sat = 1'b0;
`endif

    // Accumulator register: load first digit, fold in later ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (load) begin
            acc <= pp;
        end else if (step) begin
            acc <= next;
        end
    end

endmodule

// File: rtl/shift_acc_lanes.sv
// shift_acc_lanes: multi-lane digit-serial shift-and-accumulate with
// valid/ready handshake. Optional saturation via SHIFT_ACC_SAT_EN.
module shift_acc_lanes
    import shift_acc_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter int unsigned SIZE   = 18,
    parameter int unsigned SHIFT  = 3,
    parameter int unsigned DIGITS = 6
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        abort_i,
    input  logic                        pp_valid_i,
    output logic                        pp_ready_o,
    input  logic [LANES-1:0][SIZE-1:0]  pp_i,
    output logic                        res_valid_o,
    input  logic                        res_ready_i,
    output logic [LANES-1:0][SIZE-1:0]  res_o,
    output logic [LANES-1:0]            sat_o,
    output logic                        busy_o
);

    localparam int unsigned CW = $clog2(DIGITS + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          ready;
    logic          valid;
    logic          busy;
    logic          beat;
    logic          load;
    logic          step;

    assign pp_ready_o  = ready & rst_ni;
    assign res_valid_o = valid;
    assign busy_o      = busy;

    assign beat = pp_valid_i & pp_ready_o;
    assign load = beat & ~abort_i & (state == IDLE);
    assign step = beat & ~abort_i & (state == ACC);

    // Control FSM with registered handshake/status outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || abort_i) begin
            state <= IDLE;
            cnt   <= '0;
            ready <= 1'b1;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat) begin
                        cnt  <= CW'(1);
                        busy <= 1'b1;
                        if (DIGITS == 1) begin
                            state <= DONE;
                            ready <= 1'b0;
                            valid <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (beat) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(DIGITS - 1)) begin
                            state <= DONE;
                            ready <= 1'b0;
                            valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (res_ready_i) begin
                        state <= IDLE;
                        cnt   <= '0;
                        ready <= 1'b1;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    ready <= 1'b1;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        shift_acc_lane #(
            .SIZE  (SIZE),
            .SHIFT (SHIFT)
        ) u_lane (
            .clk   (clk_i),
            .rst_n (rst_ni),
            .load  (load),
            .step  (step),
            .pp    (pp_i[i]),
            .acc   (res_o[i]),
            .sat   (sat_o[i])
        );
    end

endmodule

// File: doc/shift_acc_lanes.md
# shift_acc_lanes

Multi-lane sequential shift-and-accumulate unit for radix-2^SHIFT digit-serial multiplication in the AI core datapath. Each of LANES lanes takes one signed partial product per beat, most-significant digit first, and folds it into a per-lane accumulator: acc = (acc << SHIFT) + pp. After DIGITS beats the unit presents the full result through a valid/ready handshake. It replaces fixed, stateless radix-8 shift stages with a parametrised, back-pressured accumulator sitting between the partial-product generator and the output adder tree.

## Interface
- LANES, 4, number of independent lanes
- SIZE, 18, accumulator and partial-product width (two's complement)
- SHIFT, 3, shift per digit; radix = 2^SHIFT; must be 1..SIZE-1
- DIGITS, 6, partial products per operation; must be ≥1
- clk_i  in  1  clock
- rst_ni  in  1  reset: synchronous, active-low
- abort_i  in  1  discard the current operation and return to IDLE
- pp_valid_i  in  1  partial-product beat valid
- pp_ready_o  out  1  unit accepts a beat
- pp_i  in  [LANES-1:0][SIZE-1:0]  signed partial products, one per lane
- res_valid_o  out  1  result available
- res_ready_i  in  1  consumer accepts result
- res_o  out  [LANES-1:0][SIZE-1:0]  accumulated results
- sat_o  out  [LANES-1:0]  per-lane sticky saturation flag (see Configuration)
- busy_o  out  1  state != IDLE

## Operation
- FSM states: IDLE, ACC, DONE. A beat is pp_valid_i && pp_ready_o.
- IDLE:
  - pp_ready_o=1.
  - On a beat: acc=pp_i (load, no shift), cnt=1, sat cleared.
  - Next state is DONE if DIGITS==1, otherwise ACC.
- ACC:
  - pp_ready_o=1.
  - On a beat: acc = {acc[SIZE-1-SHIFT:0], SHIFT'b0} + pp_i, modulo 2^SIZE; cnt++.
  - The beat taken at cnt==DIGITS-1 moves to DONE.
  - No beat: hold.
- DONE:
  - pp_ready_o=0, res_valid_o=1, res_o=acc.
  - On res_ready_i: go to IDLE; acc and sat hold until the next load.
- abort_i:
  - From any state, go to IDLE on the next edge; cnt=0, res_valid_o drops.
  - Abort wins over a simultaneous beat or result handshake (the beat is not consumed; a result handshaken in the same cycle is still dropped).
- Lanes share the FSM and cnt; per-lane arithmetic is independent.
- res_o is driven directly from the accumulator register. It is stable for the whole time res_valid_o is high.

## Timing
- Reset (rst_ni=0 at a rising edge):
  - State becomes IDLE; acc=0, cnt=0, sat_o=0, res_valid_o=0, busy_o=0.
  - pp_ready_o is gated to 0 while rst_ni is low.
  - Reset mid-operation discards all progress.
- Latency: res_valid_o rises on the cycle after the DIGITS-th beat.
- Best-case throughput: one operation per DIGITS+1 cycles. This requires back-to-back beats and res_ready_i=1 on the first DONE cycle.
- pp_ready_o, res_valid_o and busy_o are decoded from registered state only. There is no combinational path from res_ready_i or pp_valid_i to any output.
- pp_valid_i gaps in ACC stall accumulation without penalty.

## Configuration
- SHIFT_ACC_SAT_EN defined:
  - Each lane checks the shift step: bits shifted out plus the new MSB must all equal the old sign bit.
  - Each lane checks the add step for signed overflow.
  - On overflow, acc clamps to 2^(SIZE-1)-1 or -2^(SIZE-1), following the sign of the true result, and that lane's sat_o is set.
  - sat_o is sticky until the next IDLE load or reset.
- Not defined: pure modulo-2^SIZE wrap, and sat_o is tied to 0.
- The sat_o port exists in both builds.

## Structure
- Package shift_acc_pkg:
  - state enum (IDLE, ACC, DONE)
  - function computing the saturation limits from SIZE
  - shift-overflow check function
- Sub-module shift_acc_lane holds the single-lane datapath: shift, add, optional saturation, acc and sat registers. It is instantiated LANES times by a generate loop.
- The top level holds the FSM, cnt (width $clog2(DIGITS+1)) and the handshake.

## Test plan
- DIGITS=3, SHIFT=3, lane 0 beats 1,2,3 back-to-back, res_ready_i=1 → res_o[0]=83 (0x00053), res_valid_o exactly one cycle after beat 3, busy_o low the following cycle.
- DIGITS=3, lane 1 beats -1,0,0 → res_o[1]=0x3FFC0 (-64), sat_o=0.
- DIGITS=6, SIZE=18, all beats 7:
  - Without SHIFT_ACC_SAT_EN → res_o=0x3FFFF, sat_o=0.
  - With SHIFT_ACC_SAT_EN → res_o=0x1FFFF, sat_o=1.
- res_ready_i held low 4 cycles in DONE with pp_valid_i=1 → pp_ready_o=0, res_o unchanged, no beat consumed; the next operation loads fresh after the handshake.
- abort_i asserted together with the 2nd beat → IDLE next cycle, no res_valid_o; the next 3-beat operation gives the correct result.
- rst_ni pulled low for one cycle after the 2nd of 6 beats → all outputs at reset values; a new 6-beat operation gives the correct result.
